// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo
//   Store-and-forward frame FIFO behind the 10G MAC rx AXIS output. The MAC
//   cannot be backpressured, so frames are absorbed at line rate. Frames that
//   the MAC flags bad (tuser=1 on tlast), or that do not fit in the buffer,
//   are rolled back and never become visible. Only complete good frames are
//   presented on the backpressurable AXIS master.
// Ports
//   clk, rst            : rx MAC clock, asynchronous active-high reset
//   s_axis_*            : rx beats from the MAC (no tready)
//   m_axis_*            : committed frames to user logic (FWFT output register)
//   good_frames         : frames committed to the buffer
//   bad_frames          : frames dropped because tuser=1
//   overflow_frames     : frames dropped because the buffer was full
module rx_frame_fifo #(
  parameter int C_ADDR_WIDTH = 9,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            s_axis_tdata,
  input  logic [7:0]             s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [63:0]            m_axis_tdata,
  output logic [7:0]             m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0] good_frames,
  output logic [C_CNT_WIDTH-1:0] bad_frames,
  output logic [C_CNT_WIDTH-1:0] overflow_frames
);

  localparam int DEPTH = 2 ** C_ADDR_WIDTH;

  logic [72:0]             mem [DEPTH];
  logic [C_ADDR_WIDTH-1:0] wr_ptr;
  logic [C_ADDR_WIDTH-1:0] commit_ptr;
  logic [C_ADDR_WIDTH-1:0] rd_ptr;
  logic [C_ADDR_WIDTH-1:0] wr_ptr_inc;
  logic                    in_sync;
  logic                    dropping;

  logic                    full;
  logic                    accept;
  logic                    do_write;

  logic [72:0]             ram_q;
  logic                    q_valid;
  logic                    avail;
  logic                    load_out;
  logic                    rd_fire;

  always_comb begin
    wr_ptr_inc = wr_ptr + C_ADDR_WIDTH'(1);
    // Full is judged against the registered rd_ptr; a read in the same cycle
    // does not free a slot until the next cycle.
    full       = (wr_ptr_inc == rd_ptr);
    accept     = s_axis_tvalid & in_sync;
    do_write   = accept & ~full & ~dropping;
  end

  // Write side: sync tracking, frame commit/rollback and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      in_sync         <= 1'b0;
      dropping        <= 1'b0;
      good_frames     <= '0;
      bad_frames      <= '0;
      overflow_frames <= '0;
    end else if (!in_sync) begin
      // A tlast seen while out of sync ends the partial frame; that beat is discarded.
      if (!s_axis_tvalid || s_axis_tlast) begin
        in_sync <= 1'b1;
      end
    end else if (accept) begin
      if (s_axis_tlast) begin
        dropping <= 1'b0;
        if (do_write && !s_axis_tuser) begin
          wr_ptr      <= wr_ptr_inc;
          commit_ptr  <= wr_ptr_inc;
          good_frames <= good_frames + C_CNT_WIDTH'(1);
        end else if (dropping || full) begin
          wr_ptr          <= commit_ptr;
          overflow_frames <= overflow_frames + C_CNT_WIDTH'(1);
        end else begin
          wr_ptr     <= commit_ptr;
          bad_frames <= bad_frames + C_CNT_WIDTH'(1);
        end
      end else if (do_write) begin
        wr_ptr <= wr_ptr_inc;
      end else if (full) begin
        dropping <= 1'b1;
      end
    end
  end

  // Read side: RAM output stage (ram_q/q_valid) feeding the output register.
  // The RAM stage refills in the same cycle the output register loads, which
  // sustains one beat per clock while tready stays high.
  always_comb begin
    avail    = (rd_ptr != commit_ptr);
    load_out = q_valid & (~m_axis_tvalid | m_axis_tready);
    rd_fire  = avail & (~q_valid | load_out);
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
    if (rd_fire) begin
      ram_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      q_valid       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      if (rd_fire) begin
        rd_ptr <= rd_ptr + C_ADDR_WIDTH'(1);
      end
      q_valid <= rd_fire | (q_valid & ~load_out);
      if (load_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= ram_q[72];
        m_axis_tkeep  <= ram_q[71:64];
        m_axis_tdata  <= ram_q[63:0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
